// File: rtl/core_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter_pkg
// Purpose  : Shared types and default widths for the imem/dmem memory arbiter.
//            Holds the owner encoding, the default memory interface widths,
//            and the saturating starvation-counter helper.
// Revision : 1.0 - initial release
// ============================================================================
package core_mem_arbiter_pkg;

  // Default widths of the shared memory interface.
  localparam int c_mem_addr_w     = 64;
  localparam int c_mem_data_w     = 64;
  localparam int c_mem_strb_w     = c_mem_data_w / 8;

  // Starvation guard: default limit and counter width.
  // A 4-bit counter covers the whole legal limit range of 1..15.
  localparam int c_starve_limit   = 4;
  localparam int c_starve_w       = 4;

  // Current owner of the downstream port.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  // Increment the starvation count, holding it at the limit once reached.
  function automatic logic [c_starve_w-1:0] starve_inc(
    input logic [c_starve_w-1:0] cnt,
    input logic [c_starve_w-1:0] lim
  );
    return (cnt >= lim) ? lim : cnt + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter
// Purpose  : Shares one downstream memory port between the instruction (imem)
//            and data (dmem) request interfaces. Arbitration is registered:
//            dmem has fixed priority, and a starvation guard forces an imem
//            turn after STARVE_LIMIT consecutive contested dmem wins.
// Ports    :
//   g_clk, g_resetn            clock, asynchronous active-low reset
//   imem_req/addr/wen/strb/wdata  imem request, held until imem_gnt
//   imem_gnt/err/rdata         imem completion, error and read data
//   dmem_*                     same set as imem_*, for the data side
//   mem_req/addr/wen/strb/wdata   downstream request, muxed from owner
//   mem_gnt/err/rdata          downstream completion, error and read data
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_W   = c_mem_addr_w,
  parameter int MEM_DATA_W   = c_mem_data_w,
  parameter int MEM_STRB_W   = c_mem_strb_w,
  parameter int STARVE_LIMIT = c_starve_limit   // legal range 1..15
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,

  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic                  imem_wen,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,

  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,

  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  localparam logic [c_starve_w-1:0] c_limit = c_starve_w'(STARVE_LIMIT);

  owner_e                r_owner;
  owner_e                w_owner_nxt;
  logic [c_starve_w-1:0] r_starve;
  logic [c_starve_w-1:0] w_starve_nxt;
  logic                  w_force_i;

  // imem has waited through enough contested dmem wins: it takes the next turn.
  assign w_force_i = imem_req && (r_starve >= c_limit);

  // --------------------------------------------------------------------------
  // Next-state logic: owner and starvation counter
  // --------------------------------------------------------------------------
  always_comb begin
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve;
    case (r_owner)
      OWN_IDLE: begin
        if (dmem_req && !w_force_i) begin
          w_owner_nxt = OWN_D;
          // Only a contested win counts against imem.
          if (imem_req) begin
            w_starve_nxt = starve_inc(r_starve, c_limit);
          end
        end else if (imem_req) begin
          w_owner_nxt  = OWN_I;
          w_starve_nxt = '0;
        end
      end
      // A dropped request abandons the transfer; a later mem_gnt then lands
      // in IDLE where it is ignored.
      OWN_I: begin
        if (!imem_req || mem_gnt) begin
          w_owner_nxt = OWN_IDLE;
        end
      end
      OWN_D: begin
        if (!dmem_req || mem_gnt) begin
          w_owner_nxt = OWN_IDLE;
        end
      end
      default: begin
        w_owner_nxt = OWN_IDLE;
      end
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_owner  <= OWN_IDLE;
      r_starve <= '0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Owner-selected request mux and response steering.
  // Decoded straight from the owner register so that an asynchronous reset
  // drops mem_req without waiting for a clock.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_wen    = 1'b0;
    mem_strb   = '0;
    mem_wdata  = '0;
    imem_gnt   = 1'b0;
    imem_err   = 1'b0;
    dmem_gnt   = 1'b0;
    dmem_err   = 1'b0;
    // Read data is broadcast; gnt is what qualifies it.
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;
    case (r_owner)
      OWN_I: begin
        mem_req   = imem_req;
        mem_addr  = imem_addr;
        mem_wen   = imem_wen;
        mem_strb  = imem_strb;
        mem_wdata = imem_wdata;
        imem_gnt  = imem_req && mem_gnt;
        imem_err  = imem_req && mem_gnt && mem_err;
      end
      OWN_D: begin
        mem_req   = dmem_req;
        mem_addr  = dmem_addr;
        mem_wen   = dmem_wen;
        mem_strb  = dmem_strb;
        mem_wdata = dmem_wdata;
        dmem_gnt  = dmem_req && mem_gnt;
        dmem_err  = dmem_req && mem_gnt && mem_err;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_arbiter
// Purpose  : Self-checking bench for core_mem_arbiter. A transaction-level
//            arbitration model queues the expected downstream transfers; a
//            separate monitor compares every downstream handshake against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int SW  = 8;
  localparam int LIM = 4;

  logic          g_clk = 1'b0;
  logic          g_resetn = 1'b1;
  logic          imem_req = 1'b0, imem_wen = 1'b0;
  logic [AW-1:0] imem_addr = '0;
  logic [SW-1:0] imem_strb = '0;
  logic [DW-1:0] imem_wdata = '0;
  logic          dmem_req = 1'b0, dmem_wen = 1'b0;
  logic [AW-1:0] dmem_addr = '0;
  logic [SW-1:0] dmem_strb = '0;
  logic [DW-1:0] dmem_wdata = '0;
  logic          imem_gnt, imem_err, dmem_gnt, dmem_err;
  logic [DW-1:0] imem_rdata, dmem_rdata;
  logic          mem_req, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_strb;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0, mem_err = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  core_mem_arbiter #(
    .MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(SW), .STARVE_LIMIT(LIM)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_strb(imem_strb), .imem_wdata(imem_wdata),
    .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  initial forever #5 g_clk = ~g_clk;

  int cyc = 0;
  initial forever begin
    @(posedge g_clk);
    cyc++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected downstream transfers, in service order.
  typedef struct {
    bit            is_d;
    logic [AW-1:0] addr;
    logic          wen;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
    int            dcyc;
  } txn_t;

  txn_t exp_q[$];
  bit   served[$];       // 1 = dmem, 0 = imem, in completion order
  int   i_issued = 0, d_issued = 0, i_done = 0, d_done = 0;

  // --------------------------------------------------------------------------
  // Reference model: one transfer at a time. When the port is free (and not
  // in the cycle of a completion), the pending requests are arbitrated:
  // dmem first, unless imem has lost LIM contested rounds in a row.
  // --------------------------------------------------------------------------
  initial begin
    bit   busy = 0;
    int   losses = 0;
    txn_t t;
    forever begin
      @(negedge g_clk);
      if (!g_resetn) begin
        busy = 0;
        losses = 0;
        exp_q.delete();
        continue;
      end
      if (busy) begin
        if (mem_req && mem_gnt) busy = 0;
      end else if (imem_req || dmem_req) begin
        if (dmem_req && !(imem_req && losses >= LIM)) begin
          t = '{1'b1, dmem_addr, dmem_wen, dmem_strb, dmem_wdata, cyc};
          if (imem_req && losses < LIM) losses++;
        end else begin
          t = '{1'b0, imem_addr, imem_wen, imem_strb, imem_wdata, cyc};
          losses = 0;
        end
        exp_q.push_back(t);
        busy = 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: compares every downstream cycle against the expected queue.
  // --------------------------------------------------------------------------
  initial begin
    bit   started = 0;
    txn_t e;
    forever begin
      @(negedge g_clk);
      if (!g_resetn) begin
        started = 0;
        continue;
      end
      chk("dual_gnt", 64'(imem_gnt && dmem_gnt), 64'd0);
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 64'(mem_req), 64'd0);
        end else begin
          e = exp_q[0];
          if (!started) begin
            chk("req_latency", 64'(cyc), 64'(e.dcyc + 1));
            started = 1;
          end
          if (mem_gnt) begin
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wen", 64'(mem_wen), 64'(e.wen));
            chk("mem_strb", 64'(mem_strb), 64'(e.strb));
            chk("mem_wdata", mem_wdata, e.wdata);
            chk("imem_gnt", 64'(imem_gnt), 64'(!e.is_d));
            chk("dmem_gnt", 64'(dmem_gnt), 64'(e.is_d));
            chk("imem_err", 64'(imem_err), 64'(!e.is_d && mem_err));
            chk("dmem_err", 64'(dmem_err), 64'(e.is_d && mem_err));
            chk("imem_rdata", imem_rdata, mem_rdata);
            chk("dmem_rdata", dmem_rdata, mem_rdata);
            served.push_back(e.is_d);
            if (e.is_d) d_done++; else i_done++;
            void'(exp_q.pop_front());
            started = 0;
          end else begin
            chk("early_gnt", 64'(imem_gnt || dmem_gnt), 64'd0);
          end
        end
      end else begin
        chk("idle_gnt", 64'({imem_gnt, dmem_gnt, imem_err, dmem_err}), 64'd0);
        chk("idle_addr", mem_addr, 64'd0);
        chk("idle_ctl", 64'({mem_wen, mem_strb}), 64'd0);
        chk("idle_wdata", mem_wdata, 64'd0);
        if (exp_q.size() > 0 && cyc > exp_q[0].dcyc + 1)
          chk("req_missing", 64'(mem_req), 64'd1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Downstream responder: grants after a fixed or random number of cycles.
  // --------------------------------------------------------------------------
  bit            rsp_rand = 0;
  int            rsp_dly = 0;
  logic [DW-1:0] rsp_rdata = '0;
  logic          rsp_err = 1'b0;

  initial begin
    int cnt = 0;
    bit armed = 0;
    forever begin
      @(posedge g_clk);
      #1;
      if (!g_resetn || mem_gnt) begin
        mem_gnt = 1'b0;
        armed   = 0;
      end else if (mem_req) begin
        if (!armed) begin
          cnt   = rsp_rand ? int'($urandom_range(0, 3)) : rsp_dly;
          armed = 1;
        end
        if (cnt == 0) begin
          mem_gnt   = 1'b1;
          mem_rdata = rsp_rand ? {$urandom, $urandom} : rsp_rdata;
          mem_err   = rsp_rand ? ($urandom_range(0, 7) == 0) : rsp_err;
        end else begin
          cnt--;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Requester helpers
  // --------------------------------------------------------------------------
  bit            s_igant, s_dgnt, s_ierr, s_derr, s_wen;
  logic [DW-1:0] s_irdata, s_wdata;
  logic [SW-1:0] s_strb;

  task automatic set_i(input logic [AW-1:0] a, input logic w, input logic [SW-1:0] s,
                       input logic [DW-1:0] d);
    imem_addr = a; imem_wen = w; imem_strb = s; imem_wdata = d; imem_req = 1'b1;
    i_issued++;
  endtask

  task automatic set_d(input logic [AW-1:0] a, input logic w, input logic [SW-1:0] s,
                       input logic [DW-1:0] d);
    dmem_addr = a; dmem_wen = w; dmem_strb = s; dmem_wdata = d; dmem_req = 1'b1;
    d_issued++;
  endtask

  task automatic set_i_rand();
    set_i({$urandom, $urandom}, 1'($urandom), 8'($urandom), {$urandom, $urandom});
  endtask

  task automatic set_d_rand();
    set_d({$urandom, $urandom}, 1'($urandom), 8'($urandom), {$urandom, $urandom});
  endtask

  // Sample handshakes at the falling edge, return just after the rising edge.
  task automatic step();
    @(negedge g_clk);
    s_igant  = imem_req && imem_gnt;
    s_dgnt   = dmem_req && dmem_gnt;
    s_ierr   = imem_err;
    s_derr   = dmem_err;
    s_irdata = imem_rdata;
    s_wen    = mem_wen;
    s_strb   = mem_strb;
    s_wdata  = mem_wdata;
    @(posedge g_clk);
    #1;
  endtask

  // imem held throughout while dmem issues n_d back-to-back requests.
  task automatic run_contest(input int n_d, output int base);
    int d_left;
    base = served.size();
    set_i_rand();
    set_d_rand();
    d_left = n_d - 1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (s_dgnt) begin
        if (d_left > 0) begin
          set_d_rand();
          d_left--;
        end else begin
          dmem_req = 1'b0;
        end
      end
      if (s_igant) imem_req = 1'b0;
      if (!imem_req && !dmem_req) break;
    end
    chk("contest_timeout", 64'(imem_req || dmem_req), 64'd0);
  endtask

  task automatic chk_order(input string name, input int base);
    bit order [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    chk({name, "_count"}, 64'(served.size() - base), 64'd7);
    for (int k = 0; k < 7; k++)
      if (base + k < served.size())
        chk($sformatf("%s_turn%0d", name, k), 64'(served[base + k]), 64'(order[k]));
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int lat, base, d_cnt;
    bit got, seen;

    // Reset state
    #2 g_resetn = 1'b0;
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_gnt_err", 64'({imem_gnt, dmem_gnt, imem_err, dmem_err}), 64'd0);
    chk("rst_fields", 64'({mem_wen, mem_strb}), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_rdata", imem_rdata, mem_rdata);
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1'b1;

    // 1: lone imem read, downstream grants after 2 cycles
    rsp_dly = 2; rsp_rdata = 64'hDEAD; rsp_err = 1'b0;
    set_i(64'h1000, 1'b0, '0, '0);
    lat = 0; got = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      lat++;
      if (s_igant) begin got = 1; break; end
    end
    imem_req = 1'b0;
    chk("t1_done", 64'(got), 64'd1);
    chk("t1_latency", 64'(lat), 64'd4);
    chk("t1_rdata", s_irdata, 64'hDEAD);
    chk("t1_dmem_gnt", 64'(s_dgnt), 64'd0);

    // 2: simultaneous requests: dmem then imem
    rsp_dly = 1;
    run_contest(1, base);
    chk("t2_count", 64'(served.size() - base), 64'd2);
    if (served.size() >= base + 2) begin
      chk("t2_first", 64'(served[base]), 64'd1);
      chk("t2_second", 64'(served[base + 1]), 64'd0);
    end

    // 4: dmem write with downstream error
    rsp_dly = 1; rsp_err = 1'b1;
    set_d(64'h2000, 1'b1, 8'h0F, 64'h11223344);
    got = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (s_dgnt) begin got = 1; break; end
    end
    dmem_req = 1'b0;
    chk("t4_done", 64'(got), 64'd1);
    chk("t4_wen", 64'(s_wen), 64'd1);
    chk("t4_strb", 64'(s_strb), 64'h0F);
    chk("t4_wdata", s_wdata, 64'h11223344);
    chk("t4_dmem_err", 64'(s_derr), 64'd1);
    chk("t4_imem_err", 64'(s_ierr), 64'd0);
    rsp_err = 1'b0;

    // 3: starvation guard, limit 4
    run_contest(6, base);
    chk_order("t3", base);

    // 5: reset while dmem owns the port with mem_req high
    rsp_dly = 4;
    set_i_rand();
    set_d_rand();
    d_cnt = 0;
    for (int k = 0; k < 300 && d_cnt < 2; k++) begin
      step();
      if (s_dgnt) begin
        d_cnt++;
        set_d_rand();
      end
    end
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge g_clk);
      seen = mem_req;
    end
    chk("t5_owned", 64'(seen), 64'd1);
    @(posedge g_clk);
    #3 g_resetn = 1'b0;
    #1;
    chk("t5_mem_req", 64'(mem_req), 64'd0);
    chk("t5_addr", mem_addr, 64'd0);
    chk("t5_gnt", 64'({imem_gnt, dmem_gnt}), 64'd0);
    imem_req = 1'b0;
    dmem_req = 1'b0;
    i_issued--;
    d_issued--;
    @(posedge g_clk);
    #1 g_resetn = 1'b1;
    // Counter cleared by reset: imem again waits for four dmem wins.
    rsp_dly = 0;
    run_contest(6, base);
    chk_order("t5_post", base);

    // 6: random traffic
    rsp_rand = 1;
    for (int k = 0; k < 10000; k++) begin
      step();
      if (!imem_req || s_igant) begin
        if ($urandom_range(0, 1) == 1) set_i_rand(); else imem_req = 1'b0;
      end
      if (!dmem_req || s_dgnt) begin
        if ($urandom_range(0, 1) == 1) set_d_rand(); else dmem_req = 1'b0;
      end
    end
    for (int k = 0; k < 400 && (imem_req || dmem_req); k++) begin
      step();
      if (s_igant) imem_req = 1'b0;
      if (s_dgnt) dmem_req = 1'b0;
    end
    chk("drain_timeout", 64'(imem_req || dmem_req), 64'd0);
    repeat (3) @(posedge g_clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("imem_once", 64'(i_done), 64'(i_issued));
    chk("dmem_once", 64'(d_done), 64'(d_issued));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
